// File: rtl/pwm_frame_scheduler.sv
// Frame sequencer for the two drive servos: clears the timebase at frame end, double-buffers
// pulse-width commands into frame boundaries and emits registered PWM, frame tick and sample strobe.
module pwm_frame_scheduler #(
  parameter int unsigned CNT_W     = 21,
  parameter int unsigned PERIOD    = 2_000_000,
  parameter int unsigned MIN_PULSE = 100_000,
  parameter int unsigned MAX_PULSE = 200_000,
  parameter int unsigned NEUTRAL   = 150_000,
  parameter int unsigned SAMPLE_AT = 1_900_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] tb_count,
  output logic             tb_clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_left,
  input  logic [CNT_W-1:0] cmd_right,
  output logic             pwm_left,
  output logic             pwm_right,
  output logic             frame_tick,
  output logic             sample_strobe,
  output logic             sync_err
);

  localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] NEUTRAL_C = CNT_W'(NEUTRAL);
  localparam logic [CNT_W-1:0] SAMPLE_C  = CNT_W'(SAMPLE_AT);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] active_l, active_r, pend_l, pend_r;
  logic             pend_full;
  logic             run_act, at_end, over, boundary, accept;

  function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
    if (v < MIN_C)      return MIN_C;
    else if (v > MAX_C) return MAX_C;
    else                return v;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = SYNC;
      SYNC:    state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dropping enable in RUN suppresses every RUN action of that same cycle.
  assign run_act   = (state == RUN) && enable;
  assign at_end    = (tb_count == LAST_C);
  assign over      = (tb_count >= PERIOD_C);
  assign boundary  = (state == SYNC) || (run_act && at_end);
  assign tb_clear  = (state != RUN) || (tb_count >= LAST_C);
  assign cmd_ready = !pend_full;
  assign accept    = cmd_valid && !pend_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      active_l      <= NEUTRAL_C;
      active_r      <= NEUTRAL_C;
      pend_l        <= '0;
      pend_r        <= '0;
      pend_full     <= 1'b0;
      pwm_left      <= 1'b0;
      pwm_right     <= 1'b0;
      frame_tick    <= 1'b0;
      sample_strobe <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      // Accept needs an empty buffer and load needs a full one, so they never overlap.
      if (accept) begin
        pend_l    <= clamp(cmd_left);
        pend_r    <= clamp(cmd_right);
        pend_full <= 1'b1;
      end else if (boundary && pend_full) begin
        active_l  <= pend_l;
        active_r  <= pend_r;
        pend_full <= 1'b0;
      end
      pwm_left      <= run_act && !boundary && !over && (tb_count < active_l);
      pwm_right     <= run_act && !boundary && !over && (tb_count < active_r);
      frame_tick    <= run_act && at_end;
      sample_strobe <= run_act && (tb_count == SAMPLE_C);
      if (run_act && over) sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_frame_scheduler.sv
// Directed bench for pwm_frame_scheduler on a scaled-down frame, with a local timebase model.
module tb_pwm_frame_scheduler;

  localparam int P  = 200;
  localparam int SA = 190;

  logic        clk = 1'b0;
  logic        reset, enable, tb_clear, cmd_valid, cmd_ready;
  logic [11:0] tb_count, cmd_left, cmd_right, force_val;
  logic        force_req;
  logic        pwm_left, pwm_right, frame_tick, sample_strobe, sync_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] cl;
    logic [11:0] cr;
    int          el;
    int          er;
  } vec_t;
  vec_t vecs[6];

  pwm_frame_scheduler #(
    .CNT_W(12), .PERIOD(P), .MIN_PULSE(10), .MAX_PULSE(20), .NEUTRAL(15), .SAMPLE_AT(SA)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .tb_count(tb_count), .tb_clear(tb_clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_left(cmd_left), .cmd_right(cmd_right),
    .pwm_left(pwm_left), .pwm_right(pwm_right), .frame_tick(frame_tick),
    .sample_strobe(sample_strobe), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset)          tb_count <= '0;
    else if (force_req) tb_count <= force_val;
    else if (tb_clear)  tb_count <= '0;
    else                tb_count <= tb_count + 12'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_count(input int v);
    int n = 0;
    while (int'(tb_count) != v && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    chk("wait_count", int'(tb_count), v);
  endtask

  // Measures one frame starting at a frame_tick; optionally offers a command mid-frame.
  task automatic measure(input bit issue, input logic [11:0] l, input logic [11:0] r,
                         input int el, input int er);
    int n = 0, hl = 0, hr = 0, st = 0, st_at = -1, tk = 0;
    while (!frame_tick && n < P + 20) begin
      @(negedge clk);
      n++;
    end
    chk("tick_wait", int'(frame_tick), 1);
    chk("count_at_tick", int'(tb_count), 0);
    chk("ready_after_boundary", int'(cmd_ready), 1);
    for (int i = 0; i < P; i++) begin
      hl += int'(pwm_left);
      hr += int'(pwm_right);
      if (sample_strobe) begin
        st++;
        st_at = i;
      end
      if (i > 0 && frame_tick) tk++;
      if (issue && i == 50) begin
        cmd_left = l; cmd_right = r; cmd_valid = 1'b1;
      end
      if (issue && i == 51) begin
        cmd_valid = 1'b0;
        chk("ready_low_pending", int'(cmd_ready), 0);
      end
      if (issue && i == P - 1) chk("ready_low_to_boundary", int'(cmd_ready), 0);
      @(negedge clk);
    end
    chk("pwm_left_width", hl, el);
    chk("pwm_right_width", hr, er);
    chk("strobe_count", st, 1);
    chk("strobe_pos", st_at, SA + 1);
    chk("extra_ticks", tk, 0);
    chk("period_tick", int'(frame_tick), 1);
  endtask

  // Enables from IDLE and checks the first frame after SYNC: starts at 0, no tick after SYNC.
  task automatic sync_window(input int el, input int er);
    int hl = 0, hr = 0, tk = 0;
    enable = 1'b1;
    for (int i = 0; i <= P; i++) begin
      @(negedge clk);
      if (i == 1) chk("first_run_count", int'(tb_count), 0);
      hl += int'(pwm_left);
      hr += int'(pwm_right);
      tk += int'(frame_tick);
    end
    chk("sync_left_width", hl, el);
    chk("sync_right_width", hr, er);
    chk("sync_no_tick", tk, 0);
    @(negedge clk);
    chk("sync_first_tick", int'(frame_tick), 1);
  endtask

  initial begin
    int pl, pr;
    vecs[0] = '{12'd12,   12'd18, 12, 18};
    vecs[1] = '{12'd5,    12'd25, 10, 20};
    vecs[2] = '{12'd10,   12'd20, 10, 20};
    vecs[3] = '{12'd11,   12'd19, 11, 19};
    vecs[4] = '{12'd9,    12'd21, 10, 20};
    vecs[5] = '{12'd4095, 12'd0,  20, 10};

    reset = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_left = '0; cmd_right = '0;
    force_req = 1'b0; force_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm_left", int'(pwm_left), 0);
    chk("rst_pwm_right", int'(pwm_right), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_strobe", int'(sample_strobe), 0);
    chk("rst_sync_err", int'(sync_err), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_tb_clear", int'(tb_clear), 1);
    reset = 1'b0;
    @(negedge clk);

    sync_window(15, 15);
    pl = 15; pr = 15;
    for (int v = 0; v < 6; v++) begin
      measure(1'b1, vecs[v].cl, vecs[v].cr, pl, pr);
      pl = vecs[v].el;
      pr = vecs[v].er;
    end
    measure(1'b0, '0, '0, pl, pr);

    // enable drop mid-frame, then restart with unchanged widths
    wait_count(50);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_pwm_left", int'(pwm_left), 0);
    chk("dis_pwm_right", int'(pwm_right), 0);
    chk("dis_tb_clear", int'(tb_clear), 1);
    repeat (3) @(negedge clk);
    chk("dis_tb_clear_held", int'(tb_clear), 1);
    chk("dis_count_zero", int'(tb_count), 0);
    sync_window(20, 10);

    // out-of-range timebase
    wait_count(3);
    force_val = 12'd205; force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
    chk("oor_tb_clear", int'(tb_clear), 1);
    @(negedge clk);
    chk("oor_sync_err", int'(sync_err), 1);
    chk("oor_pwm_left", int'(pwm_left), 0);
    chk("oor_pwm_right", int'(pwm_right), 0);
    chk("oor_restart", int'(tb_count), 0);
    measure(1'b0, '0, '0, 20, 10);
    chk("sync_err_sticky", int'(sync_err), 1);

    // reset mid-frame discards the pending command
    wait_count(50);
    cmd_left = 12'd12; cmd_right = 12'd18; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst2_pending", int'(cmd_ready), 0);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_ready", int'(cmd_ready), 1);
    chk("rst2_sync_err", int'(sync_err), 0);
    chk("rst2_pwm", int'(pwm_left), 0);
    @(negedge clk);
    sync_window(15, 15);
    measure(1'b0, '0, '0, 15, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
